icache_refill_ctlr: RTL and testbench

- Memory-side responder to the L1 instruction cache miss/replacement interface.
- On a fetch miss, issues one line-read request to the next memory level and accepts the returned beats.
- Streams each beat into the missing cache line and pulses completion so the cache can set the line valid and release the fetch stall.
- Handles branch-redirect aborts mid-refill without corrupting the cache.

---
 rtl/icache_refill_ctlr.sv | 148 ++++++++++++++
 tb/tb_icache_refill_ctlr.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctlr.sv
// Refill controller between the L1 instruction cache and the next memory level.
// Optional wrapping critical-word-first refill: define ICACHE_CRITICAL_WORD_FIRST_EN.
module icache_refill_ctlr #(
    parameter int LINE_WORDS = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          instr_miss_f_i,
    input  logic [ADDR_WIDTH-1:0]         miss_addr_i,
    input  logic                          flush_i,
    output logic                          mem_req_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    input  logic                          mem_gnt_i,
    input  logic                          mem_rvalid_i,
    input  logic [31:0]                   mem_rdata_i,
    output logic                          refill_we_o,
    output logic [$clog2(LINE_WORDS)-1:0] refill_word_o,
    output logic [31:0]                   refill_data_o,
    output logic                          refill_done_o,
    output logic                          refill_busy_o
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_BEAT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [IDX_W-1:0]        start_q, start_d;
    logic [IDX_W-1:0]        count_q, count_d;
    logic                    abort_q, abort_d;

    logic [ADDR_WIDTH-1:0]   line_base;
    logic [ADDR_WIDTH-1:0]   miss_req_addr;
    logic [IDX_W-1:0]        miss_start;
    logic                    last_beat;
    logic                    unused_offset;

    assign line_base = {miss_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    // Memory returns a wrapping burst starting at the missing word.
    assign miss_start    = miss_addr_i[OFF_W-1:2];
    assign miss_req_addr = line_base | {{(ADDR_WIDTH-OFF_W){1'b0}}, miss_start, 2'b00};
    assign unused_offset = ^miss_addr_i[1:0];
`else
    assign miss_start    = '0;
    assign miss_req_addr = line_base;
    assign unused_offset = ^miss_addr_i[OFF_W-1:0];
`endif

    assign last_beat = (count_q == IDX_W'(LINE_WORDS - 1));

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        start_d       = start_q;
        count_d       = count_q;
        abort_d       = abort_q;
        mem_req_o     = 1'b0;
        refill_we_o   = 1'b0;
        refill_done_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_miss_f_i && !flush_i) begin
                    addr_d  = miss_req_addr;
                    start_d = miss_start;
                    count_d = '0;
                    abort_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_o = 1'b1;
                if (flush_i) begin
                    abort_d = 1'b1;
                end
                if (mem_gnt_i) begin
                    count_d = '0;
                    state_d = (abort_q || flush_i) ? S_DRAIN : S_BEAT;
                end
            end
            S_BEAT: begin
                if (flush_i) begin
                    // A redirect suppresses this cycle's write; remaining beats are only drained.
                    abort_d = 1'b1;
                    if (mem_rvalid_i) begin
                        count_d = count_q + IDX_W'(1);
                        state_d = last_beat ? S_IDLE : S_DRAIN;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (mem_rvalid_i) begin
                    refill_we_o = 1'b1;
                    count_d     = count_q + IDX_W'(1);
                    if (last_beat) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                if (mem_rvalid_i) begin
                    count_d = count_q + IDX_W'(1);
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                refill_done_o = 1'b1;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            start_q <= '0;
            count_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            start_q <= start_d;
            count_q <= count_d;
            abort_q <= abort_d;
        end
    end

    assign mem_addr_o    = addr_q;
    assign refill_word_o = start_q + count_q;
    assign refill_data_o = mem_rdata_i;
    assign refill_busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_icache_refill_ctlr.sv
// Randomized bench for icache_refill_ctlr: a memory responder, a transaction-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_icache_refill_ctlr;
    localparam int LW  = 16;
    localparam int AW  = 32;
    localparam int IW  = $clog2(LW);
    localparam int OFF = IW + 2;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    localparam bit            CWF     = 1'b1;
    localparam logic [AW-1:0] S1_ADDR = 32'h0000_1234;
    int s1_order [16] = '{13, 14, 15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
`else
    localparam bit            CWF     = 1'b0;
    localparam logic [AW-1:0] S1_ADDR = 32'h0000_1200;
    int s1_order [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif

    logic          clk_i, reset_i, instr_miss_f_i, flush_i;
    logic          flush_stim, flush_mem;
    logic [AW-1:0] miss_addr_i, mem_addr_o;
    logic          mem_req_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0]   mem_rdata_i, refill_data_o;
    logic          refill_we_o, refill_done_o, refill_busy_o;
    logic [IW-1:0] refill_word_o;

    assign flush_i = flush_stim | flush_mem;

    icache_refill_ctlr #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .instr_miss_f_i (instr_miss_f_i),
        .miss_addr_i    (miss_addr_i),
        .flush_i        (flush_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .refill_we_o    (refill_we_o),
        .refill_word_o  (refill_word_o),
        .refill_data_o  (refill_data_o),
        .refill_done_o  (refill_done_o),
        .refill_busy_o  (refill_busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int gap_mode      = 0;   // 0 back-to-back, 1 every other cycle, 2 random
    int gnt_delay_cfg = 2;   // <0 selects a random delay per request
    int flush_at_beat = -1;  // beat index at which the responder raises flush
    int beats_presented = 0;
    int beats_left = 0, wait_cnt = 0, cur_delay = 0;
    bit in_burst = 0, req_seen = 0, alt = 0, give = 0;

    initial begin
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; flush_mem = 1'b0;
        forever begin
            @(posedge clk_i); #2;
            mem_rdata_i  = $urandom;
            mem_rvalid_i = 1'b0;
            flush_mem    = 1'b0;
            if (reset_i) begin
                mem_gnt_i = 1'b0; in_burst = 0; beats_left = 0; wait_cnt = 0; req_seen = 0;
            end else begin
                if (mem_gnt_i) begin
                    mem_gnt_i = 1'b0; in_burst = 1; beats_left = LW; alt = 0;
                end else if (!in_burst && mem_req_o) begin
                    if (!req_seen) begin
                        req_seen  = 1; wait_cnt = 0;
                        cur_delay = (gnt_delay_cfg < 0) ? int'($urandom_range(0, 5)) : gnt_delay_cfg;
                    end
                    if (wait_cnt >= cur_delay) begin
                        mem_gnt_i = 1'b1; req_seen = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
                if (in_burst) begin
                    case (gap_mode)
                        0:       give = 1;
                        1:       begin give = !alt; alt = !alt; end
                        default: give = $urandom_range(0, 1) == 1;
                    endcase
                    if (beats_left > 0 && give) begin
                        mem_rvalid_i = 1'b1;
                        if (LW - beats_left == flush_at_beat) flush_mem = 1'b1;
                        beats_left--;
                        beats_presented++;
                    end
                    if (beats_left == 0 && !mem_rvalid_i) in_burst = 0;
                end
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit            m_valid = 0, m_active = 0, m_granted = 0, m_aborted = 0, m_done = 0, clean = 0;
    int            m_beats = 0, m_start = 0, m_writes = 0, dut_writes = 0;
    logic [AW-1:0] m_base = '0, m_req_addr = '0, last_req_addr = '0;
    logic [LW-1:0] m_mask = '0, dut_mask = '0;
    bit            e_busy, e_req, e_we;
    int            cyc = 0, done_total = 0, req_cycles_total = 0, last_wr_cyc = 0, last_done_cyc = 0;
    int            wr_log[$];

    initial begin
        forever begin
            @(negedge clk_i);
            cyc++;
            if (m_valid) begin
                e_busy = m_active || m_done;
                e_req  = m_active && !m_granted;
                e_we   = m_active && m_granted && !m_aborted && mem_rvalid_i && !flush_i;
                chk("busy", refill_busy_o, e_busy);
                chk("mem_req", mem_req_o, e_req);
                chk("refill_we", refill_we_o, e_we);
                chk("refill_done", refill_done_o, m_done);
                if (e_req) begin
                    chk("mem_addr", mem_addr_o, m_req_addr);
                    req_cycles_total++;
                    last_req_addr = mem_addr_o;
                end
                if (e_we) begin
                    chk("refill_word", refill_word_o, (m_start + m_beats) % LW);
                    chk("refill_data", refill_data_o, mem_rdata_i);
                end
                if (refill_we_o) begin
                    wr_log.push_back(int'(refill_word_o));
                    dut_mask[refill_word_o] = 1'b1;
                    dut_writes++;
                    last_wr_cyc = cyc;
                end
                if (refill_done_o) begin
                    done_total++;
                    last_done_cyc = cyc;
                end
            end
            // advance the model across the coming clock edge
            if (reset_i) begin
                if (m_active) $display("refill base=%08h aborted by reset after %0d beats", m_base, m_beats);
                m_valid = 1; m_active = 0; m_granted = 0; m_aborted = 0; m_done = 0; m_beats = 0;
            end else if (m_valid) begin
                if (m_done) begin
                    m_done = 0;
                end else if (!m_active) begin
                    if (instr_miss_f_i && !flush_i) begin
                        m_active = 1; m_granted = 0; m_aborted = 0; m_beats = 0;
                        m_mask = '0; m_writes = 0; dut_mask = '0; dut_writes = 0;
                        m_base     = (miss_addr_i >> OFF) << OFF;
                        m_start    = CWF ? int'((miss_addr_i >> 2) % LW) : 0;
                        m_req_addr = m_base + AW'(4 * m_start);
                    end
                end else if (!m_granted) begin
                    if (flush_i) m_aborted = 1;
                    if (mem_gnt_i) m_granted = 1;
                end else begin
                    clean = !m_aborted && !flush_i;
                    if (mem_rvalid_i) begin
                        if (clean) begin
                            m_mask[(m_start + m_beats) % LW] = 1'b1;
                            m_writes++;
                        end
                        m_beats++;
                    end
                    if (flush_i) m_aborted = 1;
                    if (m_beats == LW) begin
                        m_active = 0;
                        m_done   = clean;
                        chk("line_writes", dut_writes, m_writes);
                        chk("line_mask", dut_mask, m_mask);
                        $display("refill base=%08h start=%0d writes=%0d done=%0d",
                                 m_base, m_start, dut_writes, clean);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_miss(input logic [AW-1:0] a);
        @(posedge clk_i); #1;
        instr_miss_f_i = 1'b1; miss_addr_i = a;
        @(posedge clk_i); #1;
        instr_miss_f_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (refill_busy_o !== 1'b0 && n < budget);
        chk({tag, "_idle_in_budget"}, refill_busy_o, 0);
    endtask

    int wr0, d0, r0, b0, n;
    logic [LW-1:0] seen;

    initial begin
        reset_i = 1'b1; instr_miss_f_i = 1'b0; miss_addr_i = '0; flush_stim = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_req", mem_req_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_we", refill_we_o, 0);
        chk("rst_done", refill_done_o, 0);
        chk("rst_busy", refill_busy_o, 0);

        // Miss at 0x1234, grant after 2 cycles, back-to-back beats
        wr0 = wr_log.size(); d0 = done_total; r0 = req_cycles_total;
        start_miss(32'h0000_1234);
        wait_idle("s1", 200);
        chk("s1_req_addr", last_req_addr, S1_ADDR);
        chk("s1_req_cycles", req_cycles_total - r0, 3);
        chk("s1_writes", wr_log.size() - wr0, 16);
        for (int i = 0; i < 16 && wr0 + i < wr_log.size(); i++)
            chk("s1_order", wr_log[wr0 + i], s1_order[i]);
        chk("s1_done_cnt", done_total - d0, 1);
        chk("s1_done_after_last", last_done_cyc - last_wr_cyc, 1);

        // Beats every other cycle
        gap_mode = 1;
        wr0 = wr_log.size(); d0 = done_total;
        start_miss(32'h0000_2040);
        wait_idle("s2", 300);
        seen = '0;
        for (int i = wr0; i < wr_log.size(); i++) seen[wr_log[i]] = 1'b1;
        chk("s2_writes", wr_log.size() - wr0, 16);
        chk("s2_all_words", seen, 16'hFFFF);
        chk("s2_done_cnt", done_total - d0, 1);
        chk("s2_done_after_last", last_done_cyc - last_wr_cyc, 1);

        // Flush on the 5th beat
        gap_mode = 0; flush_at_beat = 4;
        wr0 = wr_log.size(); d0 = done_total; b0 = beats_presented;
        start_miss(32'h0000_3000);
        wait_idle("s3", 200);
        flush_at_beat = -1;
        chk("s3_writes", wr_log.size() - wr0, 4);
        for (int i = 0; i < 4 && wr0 + i < wr_log.size(); i++)
            chk("s3_order", wr_log[wr0 + i], i);
        chk("s3_beats", beats_presented - b0, 16);
        chk("s3_no_done", done_total - d0, 0);

        // Flush in REQ before the grant
        gnt_delay_cfg = 4;
        wr0 = wr_log.size(); d0 = done_total; r0 = req_cycles_total; b0 = beats_presented;
        start_miss(32'h0000_5000);
        @(posedge clk_i); #1 flush_stim = 1'b1;
        @(posedge clk_i); #1 flush_stim = 1'b0;
        wait_idle("s4", 200);
        chk("s4_req_cycles", req_cycles_total - r0, 5);
        chk("s4_writes", wr_log.size() - wr0, 0);
        chk("s4_beats", beats_presented - b0, 16);
        chk("s4_no_done", done_total - d0, 0);

        // Reset on beat 7, then a fresh miss
        gnt_delay_cfg = 1;
        b0 = beats_presented;
        start_miss(32'h0000_6000);
        n = 0;
        do begin
            @(posedge clk_i); #3;
            n++;
        end while (beats_presented - b0 < 8 && n < 200);
        chk("s5_reached_beat7", beats_presented - b0, 8);
        reset_i = 1'b1;
        @(posedge clk_i); #3 reset_i = 1'b0;
        @(negedge clk_i);
        chk("s5_req", mem_req_o, 0);
        chk("s5_addr", mem_addr_o, 0);
        chk("s5_we", refill_we_o, 0);
        chk("s5_word", refill_word_o, 0);
        chk("s5_done", refill_done_o, 0);
        chk("s5_busy", refill_busy_o, 0);
        wr0 = wr_log.size(); d0 = done_total;
        start_miss(32'h0000_7000);
        wait_idle("s5b", 200);
        chk("s5_writes", wr_log.size() - wr0, 16);
        chk("s5_first_word", (wr_log.size() > wr0) ? wr_log[wr0] : -1, 0);
        chk("s5_done_cnt", done_total - d0, 1);

        // Random traffic
        gap_mode = 2; gnt_delay_cfg = -1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk_i); #1;
            reset_i        = ($urandom_range(0, 399) == 0);
            instr_miss_f_i = ($urandom_range(0, 2) == 0);
            miss_addr_i    = $urandom;
            flush_stim     = ($urandom_range(0, 24) == 0);
        end
        @(posedge clk_i); #1;
        reset_i = 1'b0; instr_miss_f_i = 1'b0; flush_stim = 1'b0;
        wait_idle("final", 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
